i2c_reg_bridge: RTL and testbench

- Register-bank stage directly downstream of the I2C slave front end (i2c_Top_Block).
- Consumes the slave's decoded transfer strobe (i2c_xfc, i2c_op, i2c_addr_out, i2c_data_out).
- Performs register writes, and services reads by returning i2c_rdata with an i2c_xfc_read strobe.
- Exposes the register contents to core logic and accepts hardware status updates from the core.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_reg_bank.sv | 61 ++++++
 rtl/i2c_reg_bridge.sv | 133 +++++++++++++
 tb/tb_i2c_reg_bridge.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register bridge: opcodes, widths, FSM states.
package i2c_pkg;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  localparam int unsigned I2C_ADDR_W = 11;
  localparam int unsigned I2C_DATA_W = 8;

  // Register index width covers the largest legal DEPTH (64).
  localparam int unsigned IDX_W = 6;
  // Latency counter width covers the largest legal RD_LAT (7).
  localparam int unsigned CNT_W = 3;

  localparam logic [I2C_DATA_W-1:0] RDATA_OOR = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } bridge_state_e;

endpackage

// File: rtl/i2c_reg_bank.sv
// Register array with two write ports (port A = I2C, has priority over port B = core)
// and a combinational read mux that forwards a same-cycle port B write.
module i2c_reg_bank
  import i2c_pkg::*;
#(
  parameter int unsigned              DEPTH     = 16,
  parameter logic [I2C_DATA_W-1:0]    RESET_VAL = 8'h00
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        i_a_we,
  input  logic [IDX_W-1:0]            i_a_idx,
  input  logic [I2C_DATA_W-1:0]       i_a_wdata,
  input  logic                        i_b_we,
  input  logic [IDX_W-1:0]            i_b_idx,
  input  logic [I2C_DATA_W-1:0]       i_b_wdata,
  input  logic [IDX_W-1:0]            i_rd_idx,
  output logic [I2C_DATA_W-1:0]       o_rd_data,
  output logic [DEPTH*I2C_DATA_W-1:0] o_regs_flat
);

  logic [I2C_DATA_W-1:0] r_regs [DEPTH];
  logic [I2C_DATA_W-1:0] w_rd_data;

  // Register update: I2C write wins a same-index collision with the core write.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i_a_we && (i_a_idx == IDX_W'(i))) begin
          r_regs[i] <= i_a_wdata;
        end else if (i_b_we && (i_b_idx == IDX_W'(i))) begin
          r_regs[i] <= i_b_wdata;
        end
      end
    end
  end

  // Read mux; a core write to the selected index this cycle is forwarded.
  always_comb begin
    w_rd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i_rd_idx == IDX_W'(i)) begin
        w_rd_data = r_regs[i];
      end
    end
    if (i_b_we && (i_b_idx == i_rd_idx)) begin
      w_rd_data = i_b_wdata;
    end
  end

  assign o_rd_data = w_rd_data;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign o_regs_flat[g*I2C_DATA_W +: I2C_DATA_W] = r_regs[g];
  end

endmodule

// File: rtl/i2c_reg_bridge.sv
// Register-bank bridge behind the I2C slave front end: decodes transfer strobes into
// register writes and latency-controlled reads, exposes registers to the core.
// Optional macro I2C_REG_WPROT_EN: register 0 bit 0 locks registers 1..DEPTH-1
// against I2C writes.
module i2c_reg_bridge
  import i2c_pkg::*;
#(
  parameter int unsigned           DEPTH     = 16,
  parameter logic [I2C_ADDR_W-1:0] BASE_ADDR = 11'h000,
  parameter int unsigned           RD_LAT    = 2,
  parameter logic [I2C_DATA_W-1:0] RESET_VAL = 8'h00
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        i2c_xfc,
  input  logic                        i2c_op,
  input  logic [I2C_ADDR_W-1:0]       i2c_addr_out,
  input  logic [I2C_DATA_W-1:0]       i2c_data_out,
  output logic [I2C_DATA_W-1:0]       i2c_rdata,
  output logic                        i2c_xfc_read,
  input  logic                        hw_we,
  input  logic [IDX_W-1:0]            hw_addr,
  input  logic [I2C_DATA_W-1:0]       hw_wdata,
  output logic [DEPTH*I2C_DATA_W-1:0] regs_flat,
  output logic [1:0]                  err_flags
);

  bridge_state_e         r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_rd_idx;
  logic                  r_rd_oor;
  logic [I2C_DATA_W-1:0] r_rdata;
  logic                  r_xfc_read;
  logic [1:0]            r_err;

  logic [I2C_ADDR_W-1:0]       w_idx;
  logic [IDX_W-1:0]            w_idx6;
  logic                        w_above_base;
  logic                        w_in_range;
  logic                        w_is_clr;
  logic                        w_wp_block;
  logic                        w_i2c_we;
  logic                        w_hw_we;
  logic [I2C_DATA_W-1:0]       w_rd_data;
  logic [DEPTH*I2C_DATA_W-1:0] w_regs_flat;

  // Address decode; the clear address sits one past the last register.
  assign w_idx        = i2c_addr_out - BASE_ADDR;
  assign w_idx6       = w_idx[IDX_W-1:0];
  assign w_above_base = (i2c_addr_out >= BASE_ADDR);
  assign w_in_range   = w_above_base && (32'(w_idx) < DEPTH);
  assign w_is_clr     = w_above_base && (32'(w_idx) == DEPTH);

`ifdef I2C_REG_WPROT_EN
  assign w_wp_block = w_regs_flat[0] && (w_idx6 != '0);
`else
  assign w_wp_block = 1'b0;
`endif

  assign w_i2c_we = (r_state == IDLE) && i2c_xfc && (i2c_op == OP_WRITE) &&
                    w_in_range && !w_wp_block;
  assign w_hw_we  = hw_we && (32'(hw_addr) < DEPTH);

  i2c_reg_bank #(
    .DEPTH     (DEPTH),
    .RESET_VAL (RESET_VAL)
  ) u_bank (
    .Clock       (Clock),
    .Reset       (Reset),
    .i_a_we      (w_i2c_we),
    .i_a_idx     (w_idx6),
    .i_a_wdata   (i2c_data_out),
    .i_b_we      (w_hw_we),
    .i_b_idx     (hw_addr),
    .i_b_wdata   (hw_wdata),
    .i_rd_idx    (r_rd_idx),
    .o_rd_data   (w_rd_data),
    .o_regs_flat (w_regs_flat)
  );

  // Transfer FSM: read latency counter, read data / strobe, sticky error flags.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rd_idx   <= '0;
      r_rd_oor   <= 1'b0;
      r_rdata    <= '0;
      r_xfc_read <= 1'b0;
      r_err      <= 2'b00;
    end else begin
      r_xfc_read <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i2c_xfc) begin
            if (i2c_op == OP_READ) begin
              r_rd_idx <= w_idx6;
              r_rd_oor <= !w_in_range;
              r_cnt    <= CNT_W'(RD_LAT - 1);
              r_state  <= RD_WAIT;
              if (!w_in_range) r_err[0] <= 1'b1;
            end else if (w_is_clr) begin
              r_err <= 2'b00;
            end else if (!w_in_range || w_wp_block) begin
              r_err[0] <= 1'b1;
            end
          end
        end
        RD_WAIT: begin
          if (i2c_xfc) r_err[1] <= 1'b1;
          if (r_cnt == '0) begin
            r_rdata <= r_rd_oor ? RDATA_OOR : w_rd_data;
            r_state <= RD_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RD_DONE: begin
          if (i2c_xfc) r_err[1] <= 1'b1;
          r_xfc_read <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign i2c_rdata    = r_rdata;
  assign i2c_xfc_read = r_xfc_read;
  assign err_flags    = r_err;
  assign regs_flat    = w_regs_flat;

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// Directed self-checking bench for i2c_reg_bridge with default parameters
// (DEPTH=16, BASE_ADDR=0, RD_LAT=2, RESET_VAL=0).
module tb_i2c_reg_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         xfc;
  logic         op;
  logic [10:0]  addr;
  logic [7:0]   wdata;
  logic [7:0]   rdata;
  logic         xfc_read;
  logic         hw_we;
  logic [5:0]   hw_addr;
  logic [7:0]   hw_wdata;
  logic [127:0] regs_flat;
  logic [1:0]   err_flags;

  int checks   = 0;
  int failures = 0;

  logic [127:0] m_regs;
  logic [7:0]   rd_d;
  int           pulses;
  int           lat;

  always #5 clk = ~clk;

  i2c_reg_bridge dut (
    .Clock        (clk),
    .Reset        (rst),
    .i2c_xfc      (xfc),
    .i2c_op       (op),
    .i2c_addr_out (addr),
    .i2c_data_out (wdata),
    .i2c_rdata    (rdata),
    .i2c_xfc_read (xfc_read),
    .hw_we        (hw_we),
    .hw_addr      (hw_addr),
    .hw_wdata     (hw_wdata),
    .regs_flat    (regs_flat),
    .err_flags    (err_flags)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic i2c_wr(input logic [10:0] a, input logic [7:0] d);
    xfc = 1'b1; op = 1'b0; addr = a; wdata = d;
    step();
    xfc = 1'b0;
  endtask

  // Issues a read and watches a bounded window; lat = edges after the accepting edge.
  task automatic i2c_rd(input logic [10:0] a, output logic [7:0] d, output int np,
                        output int lt);
    np = 0; lt = -1; d = 8'h00;
    xfc = 1'b1; op = 1'b1; addr = a;
    step();
    xfc = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (xfc_read === 1'b1) begin
        np++;
        if (lt < 0) begin
          lt = k;
          d  = rdata;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; xfc = 1'b0; op = 1'b0; addr = '0; wdata = '0;
    hw_we = 1'b0; hw_addr = '0; hw_wdata = '0;
    m_regs = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset_rdata", rdata, 8'h00);
    chk("reset_xfc_read", xfc_read, 1'b0);
    chk("reset_err", err_flags, 2'b00);
    chk("reset_regs", regs_flat, m_regs);

    // Basic write then read
    i2c_wr(11'h003, 8'hA5);
    m_regs[31:24] = 8'hA5;
    chk("wr_reg3", regs_flat[31:24], 8'hA5);
    chk("wr_regs", regs_flat, m_regs);
    i2c_rd(11'h003, rd_d, pulses, lat);
    chk("rd3_data", rd_d, 8'hA5);
    chk("rd3_pulses", pulses, 1);
    chk("rd3_lat", lat, 3);
    chk("rd3_hold", rdata, 8'hA5);

    // Last register boundary
    i2c_wr(11'h00F, 8'hE7);
    m_regs[127:120] = 8'hE7;
    i2c_rd(11'h00F, rd_d, pulses, lat);
    chk("rd15_data", rd_d, 8'hE7);
    chk("rd15_err", err_flags, 2'b00);

    // Out-of-range read, then clear via reserved address
    i2c_rd(11'h020, rd_d, pulses, lat);
    chk("oor_rd_data", rd_d, 8'hFF);
    chk("oor_rd_lat", lat, 3);
    chk("oor_rd_err", err_flags, 2'b01);
    i2c_wr(11'h010, 8'h5C);
    chk("clr_err", err_flags, 2'b00);
    chk("clr_regs", regs_flat, m_regs);

    // Reading the reserved address is itself out of range
    i2c_rd(11'h010, rd_d, pulses, lat);
    chk("rsv_rd_data", rd_d, 8'hFF);
    chk("rsv_rd_err", err_flags, 2'b01);
    i2c_wr(11'h010, 8'h00);

    // Out-of-range write dropped
    i2c_wr(11'h020, 8'h99);
    chk("oor_wr_err", err_flags, 2'b01);
    chk("oor_wr_regs", regs_flat, m_regs);
    i2c_wr(11'h010, 8'h00);

    // Overrun: second request one cycle after read accept
    pulses = 0; lat = -1; rd_d = 8'h00;
    xfc = 1'b1; op = 1'b1; addr = 11'h003;
    step();
    xfc = 1'b1; op = 1'b0; addr = 11'h004; wdata = 8'h77;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) xfc = 1'b0;
      if (xfc_read === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          rd_d = rdata;
        end
      end
    end
    chk("ovr_data", rd_d, 8'hA5);
    chk("ovr_pulses", pulses, 1);
    chk("ovr_lat", lat, 3);
    chk("ovr_err", err_flags, 2'b10);
    chk("ovr_regs", regs_flat, m_regs);
    i2c_wr(11'h010, 8'h00);
    chk("ovr_clr", err_flags, 2'b00);

    // Write collisions
    xfc = 1'b1; op = 1'b0; addr = 11'h005; wdata = 8'h11;
    hw_we = 1'b1; hw_addr = 6'd5; hw_wdata = 8'h22;
    step();
    xfc = 1'b0; hw_we = 1'b0;
    m_regs[47:40] = 8'h11;
    chk("coll_same_reg5", regs_flat[47:40], 8'h11);
    i2c_wr(11'h005, 8'h00);
    m_regs[47:40] = 8'h00;
    xfc = 1'b1; op = 1'b0; addr = 11'h005; wdata = 8'h11;
    hw_we = 1'b1; hw_addr = 6'd6; hw_wdata = 8'h22;
    step();
    xfc = 1'b0; hw_we = 1'b0;
    m_regs[47:40] = 8'h11;
    m_regs[55:48] = 8'h22;
    chk("coll_diff_reg5", regs_flat[47:40], 8'h11);
    chk("coll_diff_reg6", regs_flat[55:48], 8'h22);
    chk("coll_regs", regs_flat, m_regs);

    // Core writes: out-of-range index ignored, in-range applied
    hw_we = 1'b1; hw_addr = 6'd16; hw_wdata = 8'h5A;
    step();
    hw_addr = 6'd7; hw_wdata = 8'h3C;
    step();
    hw_we = 1'b0;
    m_regs[63:56] = 8'h3C;
    chk("hw_regs", regs_flat, m_regs);
    chk("hw_err", err_flags, 2'b00);

    // Core write in the read's final wait cycle is visible in the returned data
    xfc = 1'b1; op = 1'b1; addr = 11'h007;
    step();
    xfc = 1'b0;
    step();
    hw_we = 1'b1; hw_addr = 6'd7; hw_wdata = 8'h4D;
    step();
    hw_we = 1'b0;
    step();
    m_regs[63:56] = 8'h4D;
    chk("byp_strobe", xfc_read, 1'b1);
    chk("byp_data", rdata, 8'h4D);
    step();
    chk("byp_strobe_low", xfc_read, 1'b0);
    chk("byp_regs", regs_flat, m_regs);

`ifdef I2C_REG_WPROT_EN
    i2c_wr(11'h000, 8'h01);
    m_regs[7:0] = 8'h01;
    i2c_wr(11'h002, 8'h33);
    chk("wp_blocked_reg2", regs_flat[23:16], 8'h00);
    chk("wp_blocked_err", err_flags, 2'b01);
    i2c_wr(11'h000, 8'h00);
    m_regs[7:0] = 8'h00;
    i2c_wr(11'h002, 8'h33);
    m_regs[23:16] = 8'h33;
    chk("wp_open_reg2", regs_flat[23:16], 8'h33);
    chk("wp_regs", regs_flat, m_regs);
    i2c_wr(11'h010, 8'h00);
`endif

    // Reset during RD_WAIT aborts the read
    xfc = 1'b1; op = 1'b1; addr = 11'h003;
    step();
    xfc = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (xfc_read === 1'b1) pulses++;
      step();
    end
    chk("rstmid_pulses", pulses, 0);
    chk("rstmid_rdata", rdata, 8'h00);
    chk("rstmid_regs", regs_flat, 128'h0);
    chk("rstmid_err", err_flags, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
